// File: rtl/ysyx_24110015_pkg.sv
// =====================================================================
// ysyx_24110015_pkg: shared fetch-path widths and reset PC
// Rev 1.0
// =====================================================================
`default_nettype none

package ysyx_24110015_pkg;

  localparam int unsigned c_mem_addr_w = 32;
  localparam int unsigned c_mem_data_w = 32;
  localparam int unsigned c_mem_err_w  = 1;
  localparam logic [31:0] c_reset_pc   = 32'h8000_0000;

  // Counter width able to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24110015_sync_fifo.sv
// =====================================================================
// ysyx_24110015_sync_fifo: circular FIFO with flush and occupancy count
// Rev 1.0
// =====================================================================
`default_nettype none

module ysyx_24110015_sync_fifo
  import ysyx_24110015_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned         c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]    c_full  = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w-1:0]  c_one   = c_ptr_w'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_ptr_w:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ~flush & ((r_count != c_full) | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + c_one;
      if (w_do_pop)  r_head <= r_head + c_one;
      r_count <= r_count + (c_ptr_w + 1)'(w_do_push) - (c_ptr_w + 1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= wdata;
  end

  assign rdata = r_mem[r_head];
  assign full  = (r_count == c_full);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ysyx_24110015_ifu_prefetch.sv
// =====================================================================
// ysyx_24110015_ifu_prefetch: in-order instruction prefetcher with flush
// Rev 1.0
// =====================================================================
`default_nettype none

module ysyx_24110015_ifu_prefetch
  import ysyx_24110015_pkg::*;
#(
  parameter int unsigned       ADDR_W   = c_mem_addr_w,
  parameter int unsigned       INST_W   = c_mem_data_w,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err
);

  localparam int unsigned       c_cnt_w = cnt_width(DEPTH);
  localparam int unsigned       c_ent_w = INST_W + ADDR_W + 1;
  localparam logic [c_cnt_w:0]  c_depth = (c_cnt_w + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_step  = ADDR_W'(4);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [ADDR_W-1:0]  r_tail_pc;
  logic               r_req_valid;
  logic               r_stale;
  logic [c_cnt_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] r_drop;

  logic               w_acc;
  logic               w_hold;
  logic               w_push;
  logic               w_pop;
  logic               w_room;
  logic [ADDR_W-1:0]  w_redirect_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [c_cnt_w-1:0] w_inflight_nxt;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [c_cnt_w:0]   w_occ_nxt;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [c_ent_w-1:0] w_fifo_rdata;

  assign w_acc         = r_req_valid & mem_req_ready;
  assign w_hold        = r_req_valid & ~mem_req_ready;
  assign w_push        = mem_rsp_valid & ~redirect_valid & (r_drop == '0);
  assign w_pop         = ~w_fifo_empty & out_ready;
  assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);

  // r_pc is the address of the next fresh request; a stale request does not advance it.
  assign w_pc_nxt = redirect_valid    ? w_redirect_pc :
                    (w_acc & ~r_stale) ? r_pc + c_step : r_pc;

  // Slots are reserved for every outstanding request, including ones to be discarded.
  assign w_inflight_nxt = r_inflight + c_cnt_w'(w_acc) - c_cnt_w'(mem_rsp_valid);
  assign w_count_nxt    = redirect_valid ? '0
                        : w_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  assign w_occ_nxt      = {1'b0, w_inflight_nxt} + {1'b0, w_count_nxt};
  assign w_room         = (w_occ_nxt < c_depth) & ~(w_fifo_full & ~w_pop & ~redirect_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_tail_pc   <= RESET_PC;
      r_req_valid <= 1'b0;
      r_stale     <= 1'b0;
      r_inflight  <= '0;
      r_drop      <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inflight <= w_inflight_nxt;

      if (w_hold) begin
        r_stale <= r_stale | redirect_valid;
      end else begin
        r_req_valid <= w_room;
        r_req_addr  <= w_pc_nxt;
        r_stale     <= 1'b0;
      end

      // On redirect every request still outstanding after this edge is discarded;
      // a held request joins the count only once it is accepted.
      if (redirect_valid) begin
        r_drop <= w_inflight_nxt;
      end else begin
        r_drop <= r_drop + c_cnt_w'(w_acc & r_stale)
                         - c_cnt_w'(mem_rsp_valid & (r_drop != '0));
      end

      if (redirect_valid) begin
        r_tail_pc <= w_redirect_pc;
      end else if (w_push) begin
        r_tail_pc <= r_tail_pc + c_step;
      end
    end
  end

  ysyx_24110015_sync_fifo #(
    .WIDTH (c_ent_w),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata ({mem_rsp_err, r_tail_pc, mem_rsp_data}),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign out_valid     = ~w_fifo_empty;
  assign {out_err, out_pc, out_inst} = w_fifo_empty ? '0 : w_fifo_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// =====================================================================
// tb_ysyx_24110015_ifu_prefetch: randomized bench with fetch-stream model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_ysyx_24110015_ifu_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;

  ysyx_24110015_ifu_prefetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } ent_t;

  mreq_t       memq[$];
  ent_t        buf_q[$];
  logic [31:0] pop_pc[$];
  logic        pop_err[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          req_epoch = 0;
  int          acc_cnt = 0;
  int          first_valid_cyc = -1;
  logic [31:0] mpc = RST_PC;
  bit          prev_hold = 0;
  logic [31:0] prev_addr = '0;
  bit          seq_ok = 0;
  logic [31:0] last_pc = '0;

  int          p_rdy = 100;
  int          p_out = 100;
  int          lat = 1;
  bit          lat_rand = 0;
  int          lat_max = 1;
  logic [31:0] err_addr = '0;
  bit          err_rand = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (a == err_addr) || (err_rand && (a[6:2] == 5'd9));
  endfunction

  function automatic int lat_pick();
    return lat_rand ? int'($urandom_range(1, lat_max)) : lat;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_err = 1'b0;
    out_ready = 1'b0;
    memq.delete();
    buf_q.delete();
    pop_pc.delete();
    pop_err.delete();
    epoch = 0;
    req_epoch = 0;
    acc_cnt = 0;
    first_valid_cyc = -1;
    mpc = RST_PC;
    prev_hold = 0;
    seq_ok = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, RST_PC);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 1;
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance model.
  task automatic step(input bit do_redir, input logic [31:0] rpc);
    bit    acc, pop, rsp, room;
    mreq_t m;
    ent_t  e;
    room = (memq.size() + buf_q.size()) < DEPTH;
    chk("occupancy", (memq.size() + buf_q.size()) <= DEPTH, 1);
    chk("out_valid", out_valid, buf_q.size() > 0);
    if (buf_q.size() > 0) begin
      chk("out_pc", out_pc, buf_q[0].pc);
      chk("out_inst", out_inst, buf_q[0].inst);
      chk("out_err", out_err, buf_q[0].err);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_hold) begin
      chk("req_hold_valid", mem_req_valid, 1);
      chk("req_hold_addr", mem_req_addr, prev_addr);
    end else begin
      chk("req_raise", mem_req_valid, room);
      if (mem_req_valid) begin
        chk("req_addr", mem_req_addr, mpc);
        req_epoch = epoch;
      end
    end

    mem_req_ready  = ($urandom_range(0, 99) < p_rdy);
    out_ready      = ($urandom_range(0, 99) < p_out);
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inst_of(memq[0].addr);
      mem_rsp_err   = is_err(memq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      mem_rsp_err   = 1'($urandom_range(0, 1));
    end
    #1;

    acc = mem_req_valid && mem_req_ready;
    pop = out_valid && out_ready;
    rsp = mem_rsp_valid;
    if (pop) begin
      pop_pc.push_back(out_pc);
      pop_err.push_back(out_err);
      if (seq_ok) chk("seq_plus4", out_pc, last_pc + 32'd4);
      last_pc = out_pc;
      seq_ok  = 1;
      if (buf_q.size() > 0) void'(buf_q.pop_front());
    end
    if (rsp) begin
      m = memq.pop_front();
      if (!do_redir && m.epoch == epoch) begin
        e.pc   = m.addr;
        e.inst = inst_of(m.addr);
        e.err  = is_err(m.addr);
        buf_q.push_back(e);
      end
    end
    if (acc) begin
      acc_cnt++;
      m.addr  = mem_req_addr;
      m.epoch = req_epoch;
      m.due   = cyc + lat_pick();
      memq.push_back(m);
      if (req_epoch == epoch) mpc = mpc + 32'd4;
    end
    prev_hold = mem_req_valid && !mem_req_ready;
    prev_addr = mem_req_addr;
    if (do_redir) begin
      epoch++;
      buf_q.delete();
      mpc    = rpc & ~32'd3;
      seq_ok = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Zero-wait memory, decode always ready.
    p_rdy = 100; p_out = 100; lat = 1; lat_rand = 0; err_addr = '0; err_rand = 0;
    do_reset();
    chk("first_req_cycle1", mem_req_valid, 1);
    chk("first_req_addr", mem_req_addr, RST_PC);
    repeat (8) step(1'b0, '0);
    chk("first_valid_cycle", first_valid_cyc, 3);
    if (pop_pc.size() >= 3) begin
      chk("t1_pop0", pop_pc[0], 32'h8000_0000);
      chk("t1_pop1", pop_pc[1], 32'h8000_0004);
      chk("t1_pop2", pop_pc[2], 32'h8000_0008);
    end else chk("t1_pops", pop_pc.size(), 3);

    // Decode stalled for 10 cycles, then resumes.
    p_out = 0;
    do_reset();
    repeat (10) step(1'b0, '0);
    chk("stall_accepts", acc_cnt, DEPTH);
    chk("stall_req_valid", mem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_pc", out_pc, RST_PC);
    p_out = 100;
    repeat (20) step(1'b0, '0);
    if (pop_pc.size() >= 8) chk("stall_pop7", pop_pc[7], 32'h8000_001c);
    else chk("stall_pops", pop_pc.size(), 8);

    // 3-cycle memory, redirect with three requests outstanding.
    lat = 3;
    do_reset();
    for (int k = 0; k < 20 && memq.size() != 3; k++) step(1'b0, '0);
    chk("t3_inflight", memq.size(), 3);
    step(1'b1, 32'h8000_1002);
    chk("t3_out_low", out_valid, 0);
    for (int k = 0; k < 30 && !out_valid; k++) step(1'b0, '0);
    chk("t3_valid", out_valid, 1);
    chk("t3_pc", out_pc, 32'h8000_1000);

    // Access fault on one fetch only.
    lat = 1; err_addr = 32'h8000_0008;
    do_reset();
    repeat (12) step(1'b0, '0);
    if (pop_pc.size() >= 4) begin
      chk("err_pc", pop_pc[2], 32'h8000_0008);
      chk("err_prev", pop_err[1], 0);
      chk("err_hit", pop_err[2], 1);
      chk("err_next", pop_err[3], 0);
    end else chk("err_pops", pop_pc.size(), 4);
    err_addr = '0;

    // Asynchronous reset with two requests outstanding.
    lat = 3;
    do_reset();
    for (int k = 0; k < 20 && memq.size() != 2; k++) step(1'b0, '0);
    chk("t5_inflight", memq.size(), 2);
    #1;
    rst = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    chk("async_req_valid", mem_req_valid, 0);
    chk("async_req_addr", mem_req_addr, RST_PC);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_pc", out_pc, 0);
    lat = 1;
    do_reset();
    for (int k = 0; k < 20 && pop_pc.size() == 0; k++) step(1'b0, '0);
    if (pop_pc.size() > 0) chk("restart_pc", pop_pc[0], RST_PC);
    else chk("restart_pops", pop_pc.size(), 1);

    // Random handshakes, latencies, faults and redirects (some near address wrap).
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      p_rdy = int'($urandom_range(30, 100));
      p_out = int'($urandom_range(30, 100));
      lat_rand = 1; lat_max = ph + 1; err_rand = 1;
      for (int i = 0; i < 2500; i++) begin
        logic [31:0] rpc;
        bit          rd;
        rd  = ($urandom_range(0, 99) < 3);
        rpc = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf))
                                          : (32'h8000_0000 + ($urandom & 32'hfff));
        step(rd, rpc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
